// File: rtl/sail_muldiv_pkg.sv
// Shared sail-core encodings for the M-extension unit: funct3 opcodes and FSM states.
package sail_muldiv_pkg;

  typedef enum logic [2:0] {
    OP_MUL    = 3'd0,
    OP_MULH   = 3'd1,
    OP_MULHSU = 3'd2,
    OP_MULHU  = 3'd3,
    OP_DIV    = 3'd4,
    OP_DIVU   = 3'd5,
    OP_REM    = 3'd6,
    OP_REMU   = 3'd7
  } op_e;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_BUSY = 2'd1,
    ST_DONE = 2'd2
  } state_e;

endpackage

// File: rtl/sail_muldiv_negate.sv
// Conditional two's-complement negation; used both to take operand magnitudes and to
// restore result signs.
module sail_muldiv_negate #(
  parameter int W = 32
) (
  input  logic [W-1:0] val_i,
  input  logic         neg_i,
  output logic [W-1:0] res_o
);

  assign res_o = neg_i ? (~val_i + {{(W-1){1'b0}}, 1'b1}) : val_i;

endmodule

// File: rtl/sail_muldiv.sv
// Iterative RV32M multiply/divide: radix-2 shift-add multiply and restoring divide,
// one bit per cycle on operand magnitudes, with valid/ready handshakes and flush.
import sail_muldiv_pkg::*;

module sail_muldiv #(
  parameter int XLEN = 32
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            in_valid,
  output logic            in_ready,
  input  logic [2:0]      in_op,
  input  logic [XLEN-1:0] in_a,
  input  logic [XLEN-1:0] in_b,
  input  logic            flush,
  output logic            out_valid,
  input  logic            out_ready,
  output logic [XLEN-1:0] out_result
);

  localparam int CNT_W = $clog2(XLEN + 1);
  localparam logic [XLEN-1:0] MOST_NEG = {1'b1, {(XLEN-1){1'b0}}};

  state_e            state_q;
  op_e               op_q;
  logic              neg_q, neg_rem_q;
  logic [XLEN-1:0]   b_mag_q;
  logic [2*XLEN-1:0] acc_q;
  logic [CNT_W-1:0]  cnt_q;
  logic              in_ready_q, out_valid_q;
  logic [XLEN-1:0]   result_q;

  logic              a_signed, b_signed, a_neg, b_neg;
  logic [XLEN-1:0]   a_mag, b_mag;
  logic              div_zero, div_ovf;
  logic [XLEN-1:0]   special_res;

  always_comb begin
    a_signed = (in_op == OP_MULH) || (in_op == OP_MULHSU) || (in_op == OP_DIV) || (in_op == OP_REM);
    b_signed = (in_op == OP_MULH) || (in_op == OP_DIV) || (in_op == OP_REM);
    a_neg    = a_signed && in_a[XLEN-1];
    b_neg    = b_signed && in_b[XLEN-1];
    div_zero = in_op[2] && (in_b == '0);
    div_ovf  = in_op[2] && !in_op[0] && (in_a == MOST_NEG) && (&in_b);
    special_res = '0;
    if (div_zero)     special_res = in_op[1] ? in_a : '1;
    else if (div_ovf) special_res = in_op[1] ? '0 : in_a;
  end

  sail_muldiv_negate #(.W(XLEN)) u_neg_a (.val_i(in_a), .neg_i(a_neg), .res_o(a_mag));
  sail_muldiv_negate #(.W(XLEN)) u_neg_b (.val_i(in_b), .neg_i(b_neg), .res_o(b_mag));

  // acc_q holds {partial high / remainder, multiplier / dividend-quotient}
  logic [XLEN:0]     mul_sum, div_shift, div_diff;
  logic              div_ge;
  logic [2*XLEN-1:0] mul_nx, div_nx, acc_nx;

  always_comb begin
    mul_sum   = {1'b0, acc_q[2*XLEN-1:XLEN]} + (acc_q[0] ? {1'b0, b_mag_q} : '0);
    mul_nx    = {mul_sum, acc_q[XLEN-1:1]};
    div_shift = {acc_q[2*XLEN-1:XLEN], acc_q[XLEN-1]};
    div_diff  = div_shift - {1'b0, b_mag_q};
    div_ge    = !div_diff[XLEN];
    div_nx    = {(div_ge ? div_diff[XLEN-1:0] : div_shift[XLEN-1:0]), acc_q[XLEN-2:0], div_ge};
    acc_nx    = op_q[2] ? div_nx : mul_nx;
  end

  logic [2*XLEN-1:0] prod_fix;
  logic [XLEN-1:0]   quo_fix, rem_fix, final_res;

  sail_muldiv_negate #(.W(2*XLEN)) u_neg_p (.val_i(acc_nx), .neg_i(neg_q), .res_o(prod_fix));
  sail_muldiv_negate #(.W(XLEN)) u_neg_q (.val_i(acc_nx[XLEN-1:0]), .neg_i(neg_q), .res_o(quo_fix));
  sail_muldiv_negate #(.W(XLEN)) u_neg_r (.val_i(acc_nx[2*XLEN-1:XLEN]), .neg_i(neg_rem_q), .res_o(rem_fix));

  always_comb begin
    final_res = '0;
    case (op_q)
      OP_MUL:                        final_res = prod_fix[XLEN-1:0];
      OP_MULH, OP_MULHSU, OP_MULHU:  final_res = prod_fix[2*XLEN-1:XLEN];
      OP_DIV, OP_DIVU:               final_res = quo_fix;
      OP_REM, OP_REMU:               final_res = rem_fix;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= ST_IDLE;
      op_q        <= OP_MUL;
      neg_q       <= 1'b0;
      neg_rem_q   <= 1'b0;
      b_mag_q     <= '0;
      acc_q       <= '0;
      cnt_q       <= '0;
      in_ready_q  <= 1'b1;
      out_valid_q <= 1'b0;
      result_q    <= '0;
    end else if (flush) begin
      state_q     <= ST_IDLE;
      cnt_q       <= '0;
      in_ready_q  <= 1'b1;
      out_valid_q <= 1'b0;
    end else begin
      case (state_q)
        ST_IDLE: begin
          if (in_valid) begin
            op_q       <= op_e'(in_op);
            neg_q      <= a_neg ^ b_neg;
            neg_rem_q  <= a_neg;
            b_mag_q    <= b_mag;
            acc_q      <= {{XLEN{1'b0}}, a_mag};
            in_ready_q <= 1'b0;
            if (div_zero || div_ovf) begin
              result_q    <= special_res;
              out_valid_q <= 1'b1;
              cnt_q       <= '0;
              state_q     <= ST_DONE;
            end else begin
              cnt_q   <= CNT_W'(XLEN);
              state_q <= ST_BUSY;
            end
          end
        end
        ST_BUSY: begin
          acc_q <= acc_nx;
          cnt_q <= cnt_q - 1'b1;
          if (cnt_q == CNT_W'(1)) begin
            result_q    <= final_res;
            out_valid_q <= 1'b1;
            state_q     <= ST_DONE;
          end
        end
        ST_DONE: begin
          if (out_ready) begin
            out_valid_q <= 1'b0;
            in_ready_q  <= 1'b1;
            state_q     <= ST_IDLE;
          end
        end
        default: state_q <= ST_IDLE;
      endcase
    end
  end

  assign in_ready   = in_ready_q;
  assign out_valid  = out_valid_q;
  assign out_result = result_q;

endmodule

// File: tb/tb_sail_muldiv.sv
// Directed bench for sail_muldiv: vector table at XLEN=32 plus back-pressure, flush,
// reset and XLEN=8 sequences.
module tb_sail_muldiv;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        in_valid, in_ready, flush, out_valid, out_ready;
  logic [2:0]  in_op;
  logic [31:0] in_a, in_b, out_result;

  logic        in_valid8, in_ready8, flush8, out_valid8, out_ready8;
  logic [2:0]  in_op8;
  logic [7:0]  in_a8, in_b8, out_result8;

  int errors = 0;
  int checks = 0;

  always #5 clk = ~clk;

  sail_muldiv #(.XLEN(32)) dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready), .in_op(in_op),
    .in_a(in_a), .in_b(in_b), .flush(flush), .out_valid(out_valid), .out_ready(out_ready),
    .out_result(out_result)
  );

  sail_muldiv #(.XLEN(8)) dut8 (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid8), .in_ready(in_ready8), .in_op(in_op8),
    .in_a(in_a8), .in_b(in_b8), .flush(flush8), .out_valid(out_valid8), .out_ready(out_ready8),
    .out_result(out_result8)
  );

  typedef struct {
    string       name;
    logic [2:0]  op;
    logic [31:0] a;
    logic [31:0] b;
    logic [31:0] exp;
    int          lat;
  } vec_t;

  vec_t vecs[12];

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  // Called just after a posedge with the unit idle; returns result and the number of
  // edges from the accepting edge (inclusive) until out_valid is seen.
  task automatic do_op(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b,
                       output logic [31:0] res, output int lat);
    in_valid = 1'b1; in_op = op; in_a = a; in_b = b;
    @(posedge clk); #1;
    in_valid = 1'b0;
    lat = 1;
    while (!out_valid && lat < 200) begin
      @(posedge clk); #1;
      lat++;
    end
    res = out_result;
    out_ready = 1'b1;
    @(posedge clk); #1;
    out_ready = 1'b0;
  endtask

  logic [31:0] res;
  int          lat;

  initial begin
    vecs[0]  = '{"mulh_minmin",   3'd1, 32'h8000_0000, 32'h8000_0000, 32'h4000_0000, 33};
    vecs[1]  = '{"mulhsu_m1",     3'd2, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 33};
    vecs[2]  = '{"mul_m1",        3'd0, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'h0000_0001, 33};
    vecs[3]  = '{"mulhu_ff",      3'd3, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFE, 33};
    vecs[4]  = '{"div_m7_2",      3'd4, 32'hFFFF_FFF9, 32'h0000_0002, 32'hFFFF_FFFD, 33};
    vecs[5]  = '{"rem_m7_2",      3'd6, 32'hFFFF_FFF9, 32'h0000_0002, 32'hFFFF_FFFF, 33};
    vecs[6]  = '{"divu_100_7",    3'd5, 32'd100,       32'd7,         32'd14,        33};
    vecs[7]  = '{"remu_100_7",    3'd7, 32'd100,       32'd7,         32'd2,         33};
    vecs[8]  = '{"divu_by0",      3'd5, 32'd5,         32'd0,         32'hFFFF_FFFF, 1};
    vecs[9]  = '{"remu_by0",      3'd7, 32'd5,         32'd0,         32'd5,         1};
    vecs[10] = '{"div_ovf",       3'd4, 32'h8000_0000, 32'hFFFF_FFFF, 32'h8000_0000, 1};
    vecs[11] = '{"rem_ovf",       3'd6, 32'h8000_0000, 32'hFFFF_FFFF, 32'h0000_0000, 1};

    rst_n = 1'b0;
    in_valid = 0; in_op = 0; in_a = 0; in_b = 0; flush = 0; out_ready = 0;
    in_valid8 = 0; in_op8 = 0; in_a8 = 0; in_b8 = 0; flush8 = 0; out_ready8 = 0;
    repeat (3) @(posedge clk);
    #1 rst_n = 1'b1;
    check("rst_in_ready", in_ready, 1);
    check("rst_out_valid", out_valid, 0);
    check("rst_out_result", out_result, 0);

    @(posedge clk); #1;
    foreach (vecs[i]) begin
      do_op(vecs[i].op, vecs[i].a, vecs[i].b, res, lat);
      check({vecs[i].name, "_res"}, res, vecs[i].exp);
      check({vecs[i].name, "_lat"}, lat, vecs[i].lat);
    end

    // back-pressure: result, valid and in_ready must hold for 10 cycles
    in_valid = 1'b1; in_op = 3'd5; in_a = 32'd100; in_b = 32'd7;
    @(posedge clk); #1;
    in_valid = 1'b0;
    for (int k = 0; k < 40 && !out_valid; k++) begin
      @(posedge clk); #1;
    end
    for (int k = 0; k < 10; k++) begin
      check("bp_result", out_result, 32'd14);
      check("bp_valid", out_valid, 1);
      check("bp_in_ready", in_ready, 0);
      @(posedge clk); #1;
    end
    out_ready = 1'b1;
    @(posedge clk); #1;
    out_ready = 1'b0;
    check("bp_release_valid", out_valid, 0);

    // flush at T+5 of a DIV, with a competing request in the same cycle
    in_valid = 1'b1; in_op = 3'd4; in_a = 32'd1000; in_b = 32'd3;
    @(posedge clk); #1;
    in_valid = 1'b0;
    repeat (4) begin @(posedge clk); #1; end
    flush = 1'b1;
    in_valid = 1'b1; in_op = 3'd0; in_a = 32'd9; in_b = 32'd9;
    @(posedge clk); #1;
    flush = 1'b0; in_valid = 1'b0;
    check("flush_out_valid", out_valid, 0);
    check("flush_in_ready", in_ready, 1);
    check("flush_result_kept", out_result, 32'd14);
    repeat (40) begin @(posedge clk); #1; end
    check("flush_no_late_valid", out_valid, 0);
    do_op(3'd0, 32'd3, 32'd4, res, lat);
    check("post_flush_mul", res, 32'd12);
    check("post_flush_lat", lat, 33);

    // asynchronous reset mid-BUSY
    in_valid = 1'b1; in_op = 3'd0; in_a = 32'd7; in_b = 32'd7;
    @(posedge clk); #1;
    in_valid = 1'b0;
    repeat (5) begin @(posedge clk); #1; end
    #2 rst_n = 1'b0;
    #1;
    check("arst_out_valid", out_valid, 0);
    check("arst_in_ready", in_ready, 1);
    check("arst_out_result", out_result, 0);
    @(posedge clk); #1;
    rst_n = 1'b1;
    repeat (40) begin @(posedge clk); #1; end
    check("arst_no_late_valid", out_valid, 0);
    do_op(3'd4, 32'd21, 32'hFFFF_FFFD, res, lat);
    check("post_rst_div", res, 32'hFFFF_FFF9);

    // XLEN=8: MULHU 0xFF*0xFF
    in_valid8 = 1'b1; in_op8 = 3'd3; in_a8 = 8'hFF; in_b8 = 8'hFF;
    @(posedge clk); #1;
    in_valid8 = 1'b0;
    lat = 1;
    while (!out_valid8 && lat < 50) begin
      @(posedge clk); #1;
      lat++;
    end
    check("x8_mulhu_res", out_result8, 8'hFE);
    check("x8_mulhu_lat", lat, 9);
    out_ready8 = 1'b1;
    @(posedge clk); #1;
    out_ready8 = 1'b0;
    check("x8_release_valid", out_valid8, 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
